// File: rtl/phy_mgmt_sequencer_if.sv
// phy_mgmt_sequencer_if: bus between the PHY management sequencer and the DM (MDIO) controller
// dm_start: one-cycle transaction start; dm_busy: controller busy
// dm_addr_mode: [10] read=1/write=0, [9:5] PHY address, [4:0] register
// dm_data_write: write data; dm_data_read: read data, valid when dm_busy falls
interface phy_mgmt_sequencer_if;
  logic        dm_start;
  logic        dm_busy;
  logic [10:0] dm_addr_mode;
  logic [15:0] dm_data_write;
  logic [15:0] dm_data_read;
  modport master(output dm_start, dm_addr_mode, dm_data_write, input dm_busy, dm_data_read);
  modport slave(input dm_start, dm_addr_mode, dm_data_write, output dm_busy, dm_data_read);
endinterface

// File: rtl/phy_mgmt_sequencer.sv
// phy_mgmt_sequencer: PHY soft reset, BMCR configuration, periodic BMSR polling and host register access
// clk_25_mhz/rst: clock and asynchronous active-high reset
// dm: master side of the DM controller bus
// host_req/host_rd/host_reg/host_wdata: host access request held until host_done
// host_rdata/host_done: host read result and one-cycle completion pulse
// init_done/init_error/link_up/an_done: configuration and link status
module phy_mgmt_sequencer #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int          POLL_CYCLES  = 25000,
  parameter int          RST_POLL_MAX = 16,
  parameter logic [15:0] CFG_BMCR     = 16'h3100
) (
  input  logic                        clk_25_mhz,
  input  logic                        rst,
  phy_mgmt_sequencer_if.master        dm,
  input  logic                        host_req,
  input  logic                        host_rd,
  input  logic [4:0]                  host_reg,
  input  logic [15:0]                 host_wdata,
  output logic [15:0]                 host_rdata,
  output logic                        host_done,
  output logic                        init_done,
  output logic                        init_error,
  output logic                        link_up,
  output logic                        an_done
);
  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int RW = $clog2(RST_POLL_MAX + 1);
  typedef enum logic [2:0] {SRST_WR, SRST_POLL, CFG_WR, POLL_WAIT, POLL_RD, HOST} state_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} phase_t;
  state_t state, state_n;
  phase_t phase, phase_n;
  logic [PW-1:0] poll_cnt, poll_cnt_n;
  logic [RW-1:0] rst_polls, rst_polls_n;
  logic [2:0] to_cnt, to_cnt_n;
  logic start, start_n;
  logic [10:0] addr, addr_n;
  logic [15:0] wdata, wdata_n, rdata_n;
  logic done_n, idone_n, ierr_n, link_n, an_n, to_poll, txn_rd;
  logic [4:0] txn_reg;
  assign dm.dm_start = start;
  assign dm.dm_addr_mode = addr;
  assign dm.dm_data_write = wdata;
  assign txn_rd = state == SRST_POLL || state == POLL_RD || (state == HOST && host_rd);
  assign txn_reg = state == HOST ? host_reg : {4'd0, state == POLL_RD};
  always_comb begin
    state_n = state;
    phase_n = phase;
    poll_cnt_n = poll_cnt;
    rst_polls_n = rst_polls;
    to_cnt_n = to_cnt;
    start_n = 1'b0;
    addr_n = addr;
    wdata_n = wdata;
    rdata_n = host_rdata;
    done_n = 1'b0;
    idone_n = init_done;
    ierr_n = init_error;
    link_n = link_up;
    an_n = an_done;
    to_poll = 1'b0;
    if (state == POLL_WAIT) begin
      // host_done is high on the first cycle back, so a held request is re-taken one cycle later
      if (host_req && !host_done) state_n = HOST;
      else if (poll_cnt == '0) state_n = POLL_RD;
      else poll_cnt_n = poll_cnt - PW'(1);
    end else
      case (phase)
        IDLE: begin
          addr_n = {txn_rd, PHY_ADDR, txn_reg};
          wdata_n = state == SRST_WR ? 16'h8000 : state == CFG_WR ? CFG_BMCR :
                    state == HOST && !host_rd ? host_wdata : 16'h0000;
          phase_n = ISSUE;
        end
        ISSUE: if (!dm.dm_busy) begin
          start_n = 1'b1;
          to_cnt_n = '0;
          phase_n = WAIT_HI;
        end
        WAIT_HI: if (dm.dm_busy) phase_n = WAIT_LO;
          else if (to_cnt == 3'd7) begin
            ierr_n = 1'b1;
            done_n = state == HOST;
            to_poll = 1'b1;
          end else to_cnt_n = to_cnt + 3'd1;
        WAIT_LO: if (!dm.dm_busy) begin
          phase_n = IDLE;
          case (state)
            SRST_WR: state_n = SRST_POLL;
            SRST_POLL: if (!dm.dm_data_read[15]) state_n = CFG_WR;
              else if (rst_polls == RW'(RST_POLL_MAX - 1)) begin
                ierr_n = 1'b1;
                to_poll = 1'b1;
              end else rst_polls_n = rst_polls + RW'(1);
            CFG_WR: begin
              idone_n = 1'b1;
              to_poll = 1'b1;
            end
            POLL_RD: begin
              link_n = dm.dm_data_read[2];
              an_n = dm.dm_data_read[5];
              to_poll = 1'b1;
            end
            default: begin
              rdata_n = host_rd ? dm.dm_data_read : host_rdata;
              done_n = 1'b1;
              to_poll = 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    // the poll interval restarts after every sequencer transaction but resumes after host access
    if (to_poll) begin
      state_n = POLL_WAIT;
      phase_n = IDLE;
      if (state != HOST) poll_cnt_n = PW'(POLL_CYCLES - 1);
    end
  end
  always_ff @(posedge clk_25_mhz or posedge rst)
    if (rst) begin
      state <= SRST_WR;
      phase <= IDLE;
      poll_cnt <= '0;
      rst_polls <= '0;
      to_cnt <= '0;
      start <= 1'b0;
      addr <= '0;
      wdata <= '0;
      host_rdata <= '0;
      host_done <= 1'b0;
      init_done <= 1'b0;
      init_error <= 1'b0;
      link_up <= 1'b0;
      an_done <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      poll_cnt <= poll_cnt_n;
      rst_polls <= rst_polls_n;
      to_cnt <= to_cnt_n;
      start <= start_n;
      addr <= addr_n;
      wdata <= wdata_n;
      host_rdata <= rdata_n;
      host_done <= done_n;
      init_done <= idone_n;
      init_error <= ierr_n;
      link_up <= link_n;
      an_done <= an_n;
    end
endmodule

// File: tb/tb_phy_mgmt_sequencer.sv
// tb_phy_mgmt_sequencer: scoreboard bench with a DM controller model for phy_mgmt_sequencer
module tb_phy_mgmt_sequencer;
  localparam int PC = 40;
  logic clk = 1'b0, rst = 1'b1;
  always #20 clk = ~clk;
  phy_mgmt_sequencer_if dm();
  logic host_req = 1'b0, host_rd = 1'b0;
  logic [4:0] host_reg = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic host_done, init_done, init_error, link_up, an_done;
  phy_mgmt_sequencer #(.PHY_ADDR(5'd1), .POLL_CYCLES(PC), .RST_POLL_MAX(16), .CFG_BMCR(16'h3100)) dut (
    .clk_25_mhz(clk), .rst(rst), .dm(dm), .host_req(host_req), .host_rd(host_rd), .host_reg(host_reg),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_done(host_done), .init_done(init_done),
    .init_error(init_error), .link_up(link_up), .an_done(an_done));
  int checks = 0, failures = 0, cyc = 0, host_dones = 0;
  logic stuck = 1'b0, no_busy = 1'b0;
  int reg0_reads, reg1_reads, bcnt;
  logic [15:0] cur_val;
  typedef struct packed {logic [10:0] a; logic [15:0] d;} txn_t;
  txn_t exp_q[$];
  txn_t e;
  logic [15:0] host_q[$];
  int start_cyc[$];
  int done_cyc[$];
  logic [10:0] cur_addr = '0;
  always @(posedge clk) cyc <= cyc + 1;
  // DM controller model: busy 3 cycles after a start, read data presented as busy falls
  always @(posedge clk or posedge rst)
    if (rst) begin
      dm.dm_busy <= 1'b0;
      dm.dm_data_read <= '0;
      bcnt <= 0;
      reg0_reads <= 0;
      reg1_reads <= 0;
      cur_val <= '0;
    end else if (dm.dm_start && !no_busy) begin
      dm.dm_busy <= 1'b1;
      bcnt <= 3;
      cur_val <= 16'h0000;
      if (dm.dm_addr_mode[10])
        case (dm.dm_addr_mode[4:0])
          5'd0: begin cur_val <= (stuck || reg0_reads == 0) ? 16'h8000 : 16'h0000; reg0_reads <= reg0_reads + 1; end
          5'd1: begin cur_val <= reg1_reads == 0 ? 16'h0000 : 16'h0024; reg1_reads <= reg1_reads + 1; end
          5'd2: cur_val <= 16'h7949;
          default: ;
        endcase
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        dm.dm_busy <= 1'b0;
        dm.dm_data_read <= cur_val;
      end
    end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (dm.dm_start) begin
      start_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        cur_addr = dm.dm_addr_mode;
        $display("FAIL dm_unexpected: got addr %h data %h, required no transaction", dm.dm_addr_mode, dm.dm_data_write);
      end else begin
        e = exp_q.pop_front();
        cur_addr = e.a;
        chk("dm_addr", {21'd0, dm.dm_addr_mode}, {21'd0, e.a});
        if (!e.a[10]) chk("dm_wdata", {16'd0, dm.dm_data_write}, {16'd0, e.d});
      end
    end else if (dm.dm_busy) chk("dm_addr_stable", {21'd0, dm.dm_addr_mode}, {21'd0, cur_addr});
    if (host_done) begin
      done_cyc.push_back(cyc);
      host_dones++;
      if (host_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL host_unexpected: got host_done with rdata %h, required none", host_rdata);
      end else chk("host_rdata", {16'd0, host_rdata}, {16'd0, host_q.pop_front()});
    end
  end
  task automatic push(logic [10:0] a, logic [15:0] d);
    exp_q.push_back({a, d});
  endtask
  task automatic wait_drain(int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic release_chk();
    rst = 1'b0;
    @(posedge clk); #1 chk("start_edge1", dm.dm_start, 0);
    @(posedge clk); #1 chk("start_edge2", dm.dm_start, 1);
    @(negedge clk);
  endtask
  task automatic chk_zero(string n);
    chk({n, "_bus"}, {dm.dm_start, dm.dm_addr_mode, dm.dm_data_write}, 0);
    chk({n, "_host"}, {host_rdata, host_done, init_done, init_error, link_up, an_done}, 0);
  endtask
  task automatic push_init();
    push(11'h020, 16'h8000);
    push(11'h420, 16'h0000);
    push(11'h420, 16'h0000);
    push(11'h020, 16'h3100);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    // normal bring-up, two polls, second poll reports link and autoneg
    push_init();
    push(11'h421, 16'h0000);
    release_chk();
    wait_drain(400);
    repeat (10) @(negedge clk);
    chk("init_done", init_done, 1);
    chk("init_error", init_error, 0);
    chk("reg0_reads", reg0_reads, 2);
    chk("link_first_poll", {link_up, an_done}, 0);
    push(11'h421, 16'h0000);
    wait_drain(200);
    repeat (10) @(negedge clk);
    chk("link_second_poll", {link_up, an_done}, 2'b11);
    chk("poll_spacing", start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2], PC + 7);
    // soft reset never clears
    hold_reset();
    stuck = 1'b1;
    push(11'h020, 16'h8000);
    for (int i = 0; i < 16; i++) push(11'h420, 16'h0000);
    push(11'h421, 16'h0000);
    release_chk();
    wait_drain(2000);
    repeat (10) @(negedge clk);
    chk("stuck_error", {init_done, init_error}, 2'b01);
    chk("stuck_reg0_reads", reg0_reads, 16);
    chk("stuck_reg1_reads", reg1_reads, 1);
    // host read raised during CFG_WR, then a held write request served twice
    hold_reset();
    stuck = 1'b0;
    push_init();
    push(11'h422, 16'h0000);
    push(11'h024, 16'hABCD);
    push(11'h024, 16'hABCD);
    push(11'h421, 16'h0000);
    release_chk();
    begin
      int n = 0;
      while (!(dm.dm_start && dm.dm_data_write == 16'h3100) && n < 200) begin @(negedge clk); n++; end
      chk("cfg_seen", n < 200, 1);
    end
    host_rd = 1'b1; host_reg = 5'd2; host_req = 1'b1;
    host_q.push_back(16'h7949);
    begin
      int n = 0;
      while (!host_done && n < 200) begin @(negedge clk); n++; end
      chk("host_rd_done", n < 200, 1);
    end
    chk("init_done_at_host", init_done, 1);
    host_rd = 1'b0; host_reg = 5'd4; host_wdata = 16'hABCD;
    host_q.push_back(16'h7949);
    host_q.push_back(16'h7949);
    begin
      int n = 0;
      while (host_dones < 3 && n < 200) begin @(negedge clk); n++; end
      chk("host_wr_done", n < 200, 1);
    end
    host_req = 1'b0;
    chk("rerequest_gap", start_cyc[start_cyc.size()-1] - done_cyc[1], 4);
    wait_drain(200);
    repeat (10) @(negedge clk);
    chk("host_done_count", host_dones, 3);
    // controller never goes busy
    hold_reset();
    no_busy = 1'b1;
    push(11'h020, 16'h8000);
    release_chk();
    repeat (7) @(posedge clk);
    #1 chk("no_abort_yet", init_error, 0);
    @(posedge clk);
    #1 chk("abort_error", {init_done, init_error}, 2'b01);
    // reset in the middle of a poll read
    hold_reset();
    no_busy = 1'b0;
    push_init();
    push(11'h421, 16'h0000);
    release_chk();
    wait_drain(400);
    begin
      int n = 0;
      while (!dm.dm_busy && n < 10) begin @(negedge clk); n++; end
      chk("poll_busy", n < 10, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1 chk_zero("mid_reset");
    push_init();
    @(negedge clk);
    release_chk();
    wait_drain(400);
    repeat (5) @(negedge clk);
    chk("restart_init_done", init_done, 1);
    chk("leftover", exp_q.size() + host_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
